// File: rtl/ex_alu_station_if.sv
// ex_alu_station_if
// Groups the reservation station's handshake and bus signals:
//   dispatch side : flush, in_valid/in_ready, in_op, in_tag{x,y,w}, in_data{x,y}, in_target
//   writeback snoop: wb_en, wb_tag, wb_data
//   ALU side      : alu_busy, alu_op, alu_tag{x,y,w}, alu_data{x,y}, alu_target
//   status        : count (occupied entries)
// slave  = the station itself; master = the environment driving it.
interface ex_alu_station_if #(
    parameter int DEPTH  = 4,
    parameter int OP_W   = 6,
    parameter int TAG_W  = 4,
    parameter int ADDR_W = 5,
    parameter int WORD_W = 32
) ();
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [OP_W-1:0]            in_op;
    logic [TAG_W-1:0]           in_tagx;
    logic [TAG_W-1:0]           in_tagy;
    logic [TAG_W-1:0]           in_tagw;
    logic [WORD_W-1:0]          in_datax;
    logic [WORD_W-1:0]          in_datay;
    logic [ADDR_W-1:0]          in_target;
    logic                       wb_en;
    logic [TAG_W-1:0]           wb_tag;
    logic [WORD_W-1:0]          wb_data;
    logic                       alu_busy;
    logic [OP_W-1:0]            alu_op;
    logic [TAG_W-1:0]           alu_tagx;
    logic [TAG_W-1:0]           alu_tagy;
    logic [TAG_W-1:0]           alu_tagw;
    logic [WORD_W-1:0]          alu_datax;
    logic [WORD_W-1:0]          alu_datay;
    logic [ADDR_W-1:0]          alu_target;
    logic [$clog2(DEPTH+1)-1:0] count;

    modport slave (
        input  flush, in_valid, in_op, in_tagx, in_tagy, in_tagw,
               in_datax, in_datay, in_target, wb_en, wb_tag, wb_data,
        output in_ready, alu_busy, alu_op, alu_tagx, alu_tagy, alu_tagw,
               alu_datax, alu_datay, alu_target, count
    );

    modport master (
        output flush, in_valid, in_op, in_tagx, in_tagy, in_tagw,
               in_datax, in_datay, in_target, wb_en, wb_tag, wb_data,
        input  in_ready, alu_busy, alu_op, alu_tagx, alu_tagy, alu_tagw,
               alu_datax, alu_datay, alu_target, count
    );
endinterface

// File: rtl/ex_alu_station.sv
// ex_alu_station
// ALU reservation station: buffers up to DEPTH dispatched operations, snoops the
// writeback broadcast to unlock operand tags, and issues the lowest-index fully
// unlocked entry to the ALU each cycle through registered outputs.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - ex_alu_station_if.slave (dispatch, writeback snoop, ALU output, count)
module ex_alu_station #(
    parameter int DEPTH    = 4,
    parameter int OP_W     = 6,
    parameter int TAG_W    = 4,
    parameter int ADDR_W   = 5,
    parameter int WORD_W   = 32,
    parameter int UNLOCKED = 0
) (
    input  logic            clk,
    input  logic            rst,
    ex_alu_station_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [TAG_W-1:0] UNLK = TAG_W'(UNLOCKED);

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  tagx;
        logic [TAG_W-1:0]  tagy;
        logic [TAG_W-1:0]  tagw;
        logic [WORD_W-1:0] datax;
        logic [WORD_W-1:0] datay;
        logic [ADDR_W-1:0] target;
    } entry_t;

    entry_t            ent_q [DEPTH];
    entry_t            ent_d [DEPTH];
    entry_t            incoming;
    logic              busy_q, busy_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [WORD_W-1:0] datax_q, datax_d;
    logic [WORD_W-1:0] datay_q, datay_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              issue_hit;
    logic [IDX_W-1:0]  issue_idx;
    logic              free_hit;
    logic [IDX_W-1:0]  free_idx;
    logic              accept;
    logic              wb_live;

    // Capture a retiring value into any operand waiting on it; the destination
    // tag only orders writes, so it is released without data.
    function automatic entry_t wake(input entry_t e, input logic hit,
                                    input logic [TAG_W-1:0] t,
                                    input logic [WORD_W-1:0] d);
        entry_t r;
        r = e;
        if (hit) begin
            if (r.tagx == t) begin
                r.datax = d;
                r.tagx  = UNLK;
            end
            if (r.tagy == t) begin
                r.datay = d;
                r.tagy  = UNLK;
            end
            if (r.tagw == t) begin
                r.tagw = UNLK;
            end
        end
        return r;
    endfunction

    // Priority scans over registered state only: lowest ready entry to issue,
    // lowest free entry to fill.
    always_comb begin
        issue_hit = 1'b0;
        issue_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!issue_hit && ent_q[i].valid && ent_q[i].tagx == UNLK &&
                ent_q[i].tagy == UNLK && ent_q[i].tagw == UNLK) begin
                issue_hit = 1'b1;
                issue_idx = IDX_W'(i);
            end
            if (!free_hit && !ent_q[i].valid) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign accept  = bus.in_valid && free_hit;
    assign wb_live = bus.wb_en && (bus.wb_tag != UNLK);

    always_comb begin
        incoming = '{valid:  1'b1,
                     op:     bus.in_op,
                     tagx:   bus.in_tagx,
                     tagy:   bus.in_tagy,
                     tagw:   bus.in_tagw,
                     datax:  bus.in_datax,
                     datay:  bus.in_datay,
                     target: bus.in_target};
    end

    always_comb begin
        ent_d    = ent_q;
        busy_d   = 1'b0;
        op_d     = op_q;
        datax_d  = datax_q;
        datay_d  = datay_q;
        target_d = target_q;
        count_d  = count_q;
        if (bus.flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
            end
            count_d = '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (ent_q[i].valid) begin
                    ent_d[i] = wake(ent_q[i], wb_live, bus.wb_tag, bus.wb_data);
                end
            end
            // The issued entry was ready before this edge, so its stored data
            // is already final; the free slot is always a different index.
            if (issue_hit) begin
                ent_d[issue_idx].valid = 1'b0;
                busy_d   = 1'b1;
                op_d     = ent_q[issue_idx].op;
                datax_d  = ent_q[issue_idx].datax;
                datay_d  = ent_q[issue_idx].datay;
                target_d = ent_q[issue_idx].target;
            end
            if (accept) begin
                ent_d[free_idx] = wake(incoming, wb_live, bus.wb_tag, bus.wb_data);
            end
            count_d = count_q + CNT_W'(accept) - CNT_W'(issue_hit);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            busy_q   <= 1'b0;
            op_q     <= '0;
            datax_q  <= '0;
            datay_q  <= '0;
            target_q <= '0;
            count_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            busy_q   <= busy_d;
            op_q     <= op_d;
            datax_q  <= datax_d;
            datay_q  <= datay_d;
            target_q <= target_d;
            count_q  <= count_d;
        end
    end

    assign bus.in_ready   = free_hit;
    assign bus.alu_busy   = busy_q;
    assign bus.alu_op     = op_q;
    assign bus.alu_datax  = datax_q;
    assign bus.alu_datay  = datay_q;
    assign bus.alu_target = target_q;
    assign bus.count      = count_q;
    // Only fully unlocked entries ever issue and reset also yields UNLOCKED,
    // so the issued tags can never hold any other value.
    assign bus.alu_tagx   = UNLK;
    assign bus.alu_tagy   = UNLK;
    assign bus.alu_tagw   = UNLK;
endmodule

// File: tb/tb_ex_alu_station.sv
// tb_ex_alu_station
// Randomized and directed stimulus for ex_alu_station, checked every cycle
// against a behavioural model of the station held in plain arrays, plus
// hand-computed literal expectations for the directed scenarios.
module tb_ex_alu_station;
    localparam int DEPTH  = 4;
    localparam int OP_W   = 6;
    localparam int TAG_W  = 4;
    localparam int ADDR_W = 5;
    localparam int WORD_W = 32;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    ex_alu_station_if #(.DEPTH(DEPTH), .OP_W(OP_W), .TAG_W(TAG_W),
                        .ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

    ex_alu_station #(.DEPTH(DEPTH), .OP_W(OP_W), .TAG_W(TAG_W),
                     .ADDR_W(ADDR_W), .WORD_W(WORD_W), .UNLOCKED(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        bit                v;
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  tx, ty, tw;
        logic [WORD_W-1:0] dx, dy;
        logic [ADDR_W-1:0] tg;
    } ment_t;

    ment_t             m [DEPTH];
    bit                e_busy = 0;
    logic [OP_W-1:0]   e_op   = '0;
    logic [WORD_W-1:0] e_dx   = '0;
    logic [WORD_W-1:0] e_dy   = '0;
    logic [ADDR_W-1:0] e_tg   = '0;
    int                e_cnt  = 0;

    function automatic ment_t mwake(input ment_t e);
        ment_t r;
        r = e;
        if (bus.wb_en && bus.wb_tag != 0) begin
            if (r.tx == bus.wb_tag) begin r.dx = bus.wb_data; r.tx = 0; end
            if (r.ty == bus.wb_tag) begin r.dy = bus.wb_data; r.ty = 0; end
            if (r.tw == bus.wb_tag) r.tw = 0;
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int    iss;
        int    fr;
        ment_t inc;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m[i].v = 0;
            e_busy = 0; e_op = '0; e_dx = '0; e_dy = '0; e_tg = '0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) m[i].v = 0;
            e_busy = 0;
        end else begin
            iss = -1;
            fr  = -1;
            for (int i = 0; i < DEPTH; i++) begin
                if (iss < 0 && m[i].v && m[i].tx == 0 && m[i].ty == 0 && m[i].tw == 0) iss = i;
                if (fr < 0 && !m[i].v) fr = i;
            end
            if (iss >= 0) begin
                e_busy = 1;
                e_op = m[iss].op; e_dx = m[iss].dx; e_dy = m[iss].dy; e_tg = m[iss].tg;
                m[iss].v = 0;
            end else begin
                e_busy = 0;
            end
            for (int i = 0; i < DEPTH; i++) if (m[i].v) m[i] = mwake(m[i]);
            if (bus.in_valid && fr >= 0) begin
                inc.v = 1; inc.op = bus.in_op;
                inc.tx = bus.in_tagx; inc.ty = bus.in_tagy; inc.tw = bus.in_tagw;
                inc.dx = bus.in_datax; inc.dy = bus.in_datay; inc.tg = bus.in_target;
                m[fr] = mwake(inc);
            end
        end
        e_cnt = 0;
        for (int i = 0; i < DEPTH; i++) if (m[i].v) e_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, well after the edge.
    always @(posedge clk) begin
        bit any_free;
        #2;
        any_free = 0;
        for (int i = 0; i < DEPTH; i++) if (!m[i].v) any_free = 1;
        check("m_busy",     bus.alu_busy,   e_busy);
        check("m_op",       bus.alu_op,     e_op);
        check("m_datax",    bus.alu_datax,  e_dx);
        check("m_datay",    bus.alu_datay,  e_dy);
        check("m_target",   bus.alu_target, e_tg);
        check("m_tagx",     bus.alu_tagx,   0);
        check("m_tagy",     bus.alu_tagy,   0);
        check("m_tagw",     bus.alu_tagw,   0);
        check("m_count",    bus.count,      e_cnt);
        check("m_in_ready", bus.in_ready,   any_free);
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        bus.in_valid = 0; bus.in_op = '0;
        bus.in_tagx = '0; bus.in_tagy = '0; bus.in_tagw = '0;
        bus.in_datax = '0; bus.in_datay = '0; bus.in_target = '0;
        bus.wb_en = 0; bus.wb_tag = '0; bus.wb_data = '0;
    endtask

    task automatic offer(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] tx,
                         input logic [TAG_W-1:0] ty, input logic [TAG_W-1:0] tw,
                         input logic [WORD_W-1:0] dx, input logic [WORD_W-1:0] dy,
                         input logic [ADDR_W-1:0] tg);
        bus.in_valid = 1; bus.in_op = op;
        bus.in_tagx = tx; bus.in_tagy = ty; bus.in_tagw = tw;
        bus.in_datax = dx; bus.in_datay = dy; bus.in_target = tg;
    endtask

    task automatic wb(input logic [TAG_W-1:0] t, input logic [WORD_W-1:0] d);
        bus.wb_en = 1; bus.wb_tag = t; bus.wb_data = d;
    endtask

    function automatic logic [TAG_W-1:0] rtag();
        return ($urandom_range(0, 1) == 0) ? TAG_W'(0) : TAG_W'($urandom_range(1, 3));
    endfunction

    logic [TAG_W-1:0] ftag [DEPTH];

    initial begin
        ftag[0] = 7; ftag[1] = 6; ftag[2] = 8; ftag[3] = 6;
        rst = 1'b1;
        bus.flush = 0;
        idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy",     bus.alu_busy,   0);
        check("rst_op",       bus.alu_op,     0);
        check("rst_datax",    bus.alu_datax,  0);
        check("rst_datay",    bus.alu_datay,  0);
        check("rst_target",   bus.alu_target, 0);
        check("rst_in_ready", bus.in_ready,   1);
        check("rst_count",    bus.count,      0);

        // Unlocked ADD: accept at E0, presented after E1, gone after E2.
        @(negedge clk); offer(6'h01, 0, 0, 0, 5, 7, 3);
        @(posedge clk);
        @(negedge clk); idle();
        @(posedge clk); #3;
        check("add_busy",   bus.alu_busy,   1);
        check("add_op",     bus.alu_op,     6'h01);
        check("add_datax",  bus.alu_datax,  5);
        check("add_datay",  bus.alu_datay,  7);
        check("add_target", bus.alu_target, 3);
        @(posedge clk); #3;
        check("add_busy_off", bus.alu_busy, 0);

        // Wakeup: locked x waits until writeback of tag 2.
        @(negedge clk); offer(6'h02, 2, 0, 0, 32'hDEAD, 9, 4);
        @(negedge clk); idle();
        repeat (3) begin
            @(posedge clk); #3;
            check("wk_hold", bus.alu_busy, 0);
        end
        @(negedge clk); wb(2, 32'h11);
        @(posedge clk);
        @(negedge clk); idle();
        @(posedge clk); #3;
        check("wk_busy",   bus.alu_busy,   1);
        check("wk_datax",  bus.alu_datax,  32'h11);
        check("wk_datay",  bus.alu_datay,  9);
        check("wk_target", bus.alu_target, 4);

        // Same-cycle bypass on accept.
        @(negedge clk); offer(6'h03, 0, 5, 0, 32'h22, 32'h1234, 7); wb(5, 32'hAB);
        @(negedge clk); idle();
        @(posedge clk); #3;
        check("byp_busy",  bus.alu_busy,  1);
        check("byp_datax", bus.alu_datax, 32'h22);
        check("byp_datay", bus.alu_datay, 32'hAB);

        // Fill all entries locked; extra offer ignored; wake entries 1 and 3.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk); offer(6'h04, ftag[i], 0, 0, 32'(i * 16), 0, ADDR_W'(i));
        end
        @(negedge clk); offer(6'h05, 0, 0, 0, 32'h99, 32'h99, 9);
        #1;
        check("full_in_ready", bus.in_ready, 0);
        check("full_count",    bus.count,    4);
        @(negedge clk); idle();
        #1;
        check("full_ignored", bus.count, 4);
        wb(6, 32'h66);
        @(negedge clk); idle();
        @(posedge clk); #3;
        check("ord1_busy",     bus.alu_busy,   1);
        check("ord1_target",   bus.alu_target, 1);
        check("ord1_datax",    bus.alu_datax,  32'h66);
        check("ord1_in_ready", bus.in_ready,   1);
        check("ord1_count",    bus.count,      3);
        @(posedge clk); #3;
        check("ord2_busy",   bus.alu_busy,   1);
        check("ord2_target", bus.alu_target, 3);
        @(posedge clk); #3;
        check("ord3_busy", bus.alu_busy, 0);

        // Flush against two ready entries and an accept.
        @(negedge clk); bus.flush = 1;
        @(negedge clk); bus.flush = 0; offer(6'h06, 9, 0, 0, 1, 1, 1);
        @(negedge clk); offer(6'h06, 9, 0, 0, 2, 2, 2);
        @(negedge clk); idle(); wb(9, 32'h5);
        @(negedge clk); idle(); bus.flush = 1; offer(6'h07, 0, 0, 0, 3, 3, 3);
        @(posedge clk); #3;
        check("fl_busy",     bus.alu_busy, 0);
        check("fl_count",    bus.count,    0);
        check("fl_in_ready", bus.in_ready, 1);
        @(negedge clk); bus.flush = 0; idle();
        @(posedge clk); #3;
        check("fl_busy_next",  bus.alu_busy, 0);
        check("fl_count_next", bus.count,    0);

        // Reset mid-burst: three locked entries plus one issuing.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); offer(6'h08, 3, 0, 0, 0, 0, ADDR_W'(i));
        end
        @(negedge clk); offer(6'h09, 0, 0, 0, 1, 2, 12);
        @(negedge clk); idle();
        @(posedge clk); #1;
        check("mid_busy",   bus.alu_busy,   1);
        check("mid_target", bus.alu_target, 12);
        check("mid_count",  bus.count,      3);
        #3 rst = 1'b1;
        #1;
        check("arst_busy",     bus.alu_busy,   0);
        check("arst_count",    bus.count,      0);
        check("arst_in_ready", bus.in_ready,   1);
        check("arst_target",   bus.alu_target, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wb(3, 32'h77);
        @(negedge clk); idle();
        repeat (3) begin
            @(posedge clk); #3;
            check("arst_no_issue", bus.alu_busy, 0);
        end

        // Randomized traffic checked by the per-cycle model compare.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            bus.flush     = ($urandom_range(0, 49) == 0);
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.in_op     = OP_W'($urandom);
            bus.in_tagx   = rtag();
            bus.in_tagy   = rtag();
            bus.in_tagw   = ($urandom_range(0, 3) == 0) ? TAG_W'($urandom_range(1, 3)) : TAG_W'(0);
            bus.in_datax  = $urandom;
            bus.in_datay  = $urandom;
            bus.in_target = ADDR_W'($urandom);
            bus.wb_en     = ($urandom_range(0, 1) == 1);
            bus.wb_tag    = TAG_W'($urandom_range(0, 3));
            bus.wb_data   = $urandom;
        end
        @(negedge clk); bus.flush = 0; idle();
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_alu_station.md
# ex_alu_station

ALU reservation station that sits between the dispatch/allocator stage and the ALU execution unit. It buffers up to DEPTH issued ALU operations, snoops the writeback broadcast to resolve locked operand tags, and drives the ALU input port. It presents one fully-unlocked operation per cycle, so the ALU sees `alu_busy` high only when its enable condition holds.

## Interface
- DEPTH, 4: number of station entries (2..8).
- OP_W, 6: ALU opcode width (`sinst_t`).
- TAG_W, 4: register tag width (`regtag_t`).
- ADDR_W, 5: register address width (`regaddr_t`).
- WORD_W, 32: data word width (`word_t`).
- UNLOCKED, 0: tag value meaning "operand available".
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all entries and the output stage.
- in_valid  in  1  dispatch offers an operation.
- in_ready  out  1  at least one entry is free.
- in_op  in  OP_W  opcode.
- in_tagx, in_tagy, in_tagw  in  TAG_W  producer tags for x, y, and destination ordering.
- in_datax, in_datay  in  WORD_W  operand values; valid only where the matching tag is UNLOCKED.
- in_target  in  ADDR_W  destination register.
- wb_en  in  1  writeback broadcast valid.
- wb_tag  in  TAG_W  tag being retired.
- wb_data  in  WORD_W  retired value.
- alu_busy  out  1  operation presented to the ALU this cycle.
- alu_op  out  OP_W; alu_tagx, alu_tagy, alu_tagw  out  TAG_W; alu_datax, alu_datay  out  WORD_W; alu_target  out  ADDR_W.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- Each entry holds: valid, op, tagx, tagy, tagw, datax, datay, target.
- **Accept:** when `in_valid && in_ready`, the lowest-index free entry is written at the edge.
- **Wakeup:** when `wb_en` is high and `wb_tag != UNLOCKED`, every valid entry with `tagx == wb_tag` loads `datax = wb_data` and sets `tagx = UNLOCKED`. tagy/datay behave the same way. A matching tagw is set to UNLOCKED with no data capture.
- **Wakeup bypass on accept:** the wakeup comparison also applies to the incoming operation in the same cycle, so an operand arriving with a tag that is retiring that cycle is stored already unlocked.
- **Ready:** an entry is ready when it is valid and all three stored tags are UNLOCKED.
- **Issue:** each edge, the lowest-index ready entry is selected.
  - Its fields are copied into the output registers and `alu_busy` is set to 1.
  - The entry is freed at the same edge.
  - With no ready entry, `alu_busy` is set to 0 and the remaining output registers hold their values.
- **Issued tag outputs:** `alu_tag*` are always UNLOCKED when `alu_busy` is 1.
- **in_ready:** equals "any entry invalid", computed from registered state only. It does not depend on `in_valid` or on an issue in the same cycle.
- **Same-entry free and refill:** a slot freed by issue at an edge becomes visible to `in_ready` in the next cycle.
- **count:** +1 on accept, −1 on issue, unchanged when both occur; it never exceeds DEPTH.
- **Flush:** has priority over accept, wakeup and issue. All entries become invalid, `alu_busy` = 0, count = 0.
- **Reset:** has the same effect as flush, applied asynchronously. Reset values of all outputs:
  - `alu_busy` = 0, `alu_op` = 0, `alu_tag*` = UNLOCKED, `alu_data*` = 0, `alu_target` = 0;
  - `in_ready` = 1, `count` = 0.
- **Wakeup with wb_tag == UNLOCKED:** no effect.
- **Wakeup on a free entry:** no effect.

## Timing
- Accept at edge E0 with all tags UNLOCKED: issue at E1, `alu_busy` high in the cycle after E1. Minimum latency is 2 edges.
- Operand woken by writeback at edge Ew: entry is ready after Ew, issues at Ew+1.
- Issue rate: at most 1 per cycle. Under back-to-back ready entries, `alu_busy` stays high on consecutive cycles.
- `alu_busy` and all `alu_*` outputs are registered. `in_ready` is registered-state combinational.
- Reset asserted mid-operation clears all state immediately. The first accept is possible on the first edge after reset deasserts.

## Test plan
- **Reset:** assert rst mid-burst with 3 entries valid → `alu_busy` = 0, `count` = 0, `in_ready` = 1 immediately; no issue after release.
- **Unlocked op:** accept ADD x=5, y=7, target=3, all tags UNLOCKED at E0 → at E1 output `alu_busy` = 1, op = ADD, datax = 5, datay = 7, target = 3, tags = UNLOCKED; `alu_busy` = 0 at E2.
- **Wakeup:** accept op with tagx=2, tagy=UNLOCKED, datay=9; hold 3 cycles with no wb → no issue. Then wb_en, wb_tag=2, wb_data=0x11 → issue one edge later with datax = 0x11, datay = 9.
- **Same-cycle bypass:** accept op with tagy=5 while wb_en, wb_tag=5, wb_data=0xAB → issues at next edge with datay = 0xAB.
- **Full and ordering:** fill DEPTH=4 entries with tags locked → `in_ready` = 0, `count` = 4, extra in_valid ignored. Wake entries 3 and 1 in the same cycle → entry 1 issues first, entry 3 on the next cycle, `in_ready` = 1 after the first issue.
- **Flush vs. issue:** assert flush in the same cycle that two ready entries and an accept occur → no issue, no accept, `count` = 0, `alu_busy` = 0 next cycle.
